sos_biquad_mac: RTL and testbench

Single second-order IIR section: consumes one input sample per handshake, computes the direct-form-I biquad output with one time-shared multiplier over five MAC cycles, and presents the result downstream with a ready/valid handshake. It sits directly downstream of the section delay registers (x[n-1], x[n-2], y[n-1], y[n-2]) and drives their enables. Sections chain output-to-input to form the cascade.

---
 rtl/sos_pkg.sv | 53 +++++
 rtl/sos_delay.sv | 26 ++
 rtl/sos_biquad_mac.sv | 163 ++++++++++++++++
 tb/tb_sos_biquad_mac.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sos_pkg.sv
// Shared types and helpers for the biquad section.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, accumulator width helper, coefficient struct,
// and the round-shift / saturate helpers used on the accumulator output.
package sos_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } sos_state_e;

  // Coefficient container; fields are wide enough for any CW up to 32 and
  // are filled with sign-extended coefficients by the section.
  localparam int COEF_W = 32;

  typedef struct packed {
    logic signed [COEF_W-1:0] b0;
    logic signed [COEF_W-1:0] b1;
    logic signed [COEF_W-1:0] b2;
    logic signed [COEF_W-1:0] a1;
    logic signed [COEF_W-1:0] a2;
  } sos_coef_t;

  // Three guard bits cover the sum of five full-scale products.
  function automatic int acc_w(input int wd, input int cw);
    return wd + cw + 3;
  endfunction

  // Accumulator already carries the rounding bias, so an arithmetic shift
  // gives round-half-up; the result is then clipped to the wd-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int frac, input int wd);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (wd - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wd - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

  function automatic logic sat_clip(input logic signed [63:0] acc,
                                    input int frac, input int wd);
    logic signed [63:0] sh;
    sh = acc >>> frac;
    return (sh > ((64'sd1 <<< (wd - 1)) - 64'sd1)) || (sh < -(64'sd1 <<< (wd - 1)));
  endfunction

endpackage

// File: rtl/sos_delay.sv
// One sample of section delay state (x[n-1], x[n-2], y[n-1] or y[n-2]).
// Latency: 1 cycle from en_i to q_o.
// Backpressure: none; loads only when en_i is high.
// Ports: clk_i clock, rst_ni async active-low reset, en_i load enable,
//        d_i next value, q_o held value.
module sos_delay
  import sos_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/sos_biquad_mac.sv
// Direct-form-I biquad section, one shared multiplier over five MAC cycles.
// Latency: output valid 5 cycles after the accept edge; one sample per 6 cycles.
// Backpressure: holds the output while out_ready_i is low; in_ready_o follows it.
// Ports: clk_i/rst_i clock and async active-high reset; clear_i sync flush;
//        b0_i..a2_i coefficients; in_* sample input handshake;
//        out_* result handshake; sat_o one-cycle clip flag with each new output.
module sos_biquad_mac
  import sos_pkg::*;
#(
  parameter int WD   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic signed [CW-1:0] b0_i,
  input  logic signed [CW-1:0] b1_i,
  input  logic signed [CW-1:0] b2_i,
  input  logic signed [CW-1:0] a1_i,
  input  logic signed [CW-1:0] a2_i,
  input  logic                 in_valid_i,
  input  logic signed [WD-1:0] in_data_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  output logic signed [WD-1:0] out_data_o,
  input  logic                 out_ready_i,
  output logic                 sat_o
);

  localparam int ACC_W = acc_w(WD, CW);
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(64'sd1 <<< (FRAC - 1));

  sos_state_e              state_q, state_d;
  logic        [2:0]       cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [WD-1:0]    x_q;
  logic signed [WD-1:0]    x1, x2, y1, y2;
  logic                    accept;
  logic                    commit;

  sos_coef_t               coef;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [WD-1:0]    opnd;
  logic                    sub;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [WD-1:0]    y_sat;
  logic                    clipped;

  assign coef = '{b0: COEF_W'(b0_i), b1: COEF_W'(b1_i), b2: COEF_W'(b2_i),
                  a1: COEF_W'(a1_i), a2: COEF_W'(a2_i)};

  // Operand/coefficient pair for this MAC step; feedback terms subtract.
  always_comb begin
    coef_sel = '0;
    opnd     = '0;
    sub      = 1'b0;
    case (cnt_q)
      3'd0: begin coef_sel = coef.b0; opnd = x_q; end
      3'd1: begin coef_sel = coef.b1; opnd = x1;  end
      3'd2: begin coef_sel = coef.b2; opnd = x2;  end
      3'd3: begin coef_sel = coef.a1; opnd = y1; sub = 1'b1; end
      3'd4: begin coef_sel = coef.a2; opnd = y2; sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = ACC_W'(coef_sel) * ACC_W'(opnd);
  assign acc_next = sub ? (acc_q - prod) : (acc_q + prod);
  assign y_sat    = WD'(sat_round(64'(acc_next), FRAC, WD));
  assign clipped  = sat_clip(64'(acc_next), FRAC, WD);

  // Final MAC step: the delay line shifts on the same edge the output loads.
  assign commit = (state_q == MAC) && (cnt_q == 3'd4) && !clear_i;

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        if (cnt_q == 3'd4) state_d = OUT;
      end
      OUT: begin
        // A new sample may enter on the very edge the result is taken.
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          if (in_valid_i) begin
            accept  = 1'b1;
            state_d = MAC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      sat_o       <= 1'b0;
    end else begin
      state_q <= state_d;
      sat_o   <= 1'b0;
      if (clear_i) begin
        acc_q       <= '0;
        cnt_q       <= '0;
        out_valid_o <= 1'b0;
      end else begin
        if (accept) begin
          x_q   <= in_data_i;
          acc_q <= ROUND_BIAS;
          cnt_q <= '0;
        end else if (state_q == MAC) begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 3'd1;
        end
        if (commit) begin
          out_data_o  <= y_sat;
          out_valid_o <= 1'b1;
          sat_o       <= clipped;
        end else if ((state_q == OUT) && out_ready_i) begin
          out_valid_o <= 1'b0;
        end
      end
    end
  end

  // Clear loads zeros through the data path with the enable forced high.
  logic                 dl_en;
  logic signed [WD-1:0] x1_d, x2_d, y1_d, y2_d;

  assign dl_en = commit || clear_i;
  assign x1_d  = clear_i ? '0 : x_q;
  assign x2_d  = clear_i ? '0 : x1;
  assign y1_d  = clear_i ? '0 : y_sat;
  assign y2_d  = clear_i ? '0 : y1;

  sos_delay #(.W(WD)) u_x1 (.clk_i(clk_i), .rst_ni(~rst_i), .en_i(dl_en), .d_i(x1_d), .q_o(x1));
  sos_delay #(.W(WD)) u_x2 (.clk_i(clk_i), .rst_ni(~rst_i), .en_i(dl_en), .d_i(x2_d), .q_o(x2));
  sos_delay #(.W(WD)) u_y1 (.clk_i(clk_i), .rst_ni(~rst_i), .en_i(dl_en), .d_i(y1_d), .q_o(y1));
  sos_delay #(.W(WD)) u_y2 (.clk_i(clk_i), .rst_ni(~rst_i), .en_i(dl_en), .d_i(y2_d), .q_o(y2));

endmodule

// File: tb/tb_sos_biquad_mac.sv
// Self-checking bench for sos_biquad_mac with a difference-equation model.
// Latency: checks the 5-cycle accept-to-valid latency on every sample.
// Backpressure: exercises held outputs and same-edge back-to-back accept.
module tb_sos_biquad_mac;
  localparam int WD   = 16;
  localparam int CW   = 16;
  localparam int FRAC = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic signed [CW-1:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
  logic in_valid = 1'b0;
  logic signed [WD-1:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic signed [WD-1:0] out_data;
  logic out_ready = 1'b0;
  logic sat;

  int errors = 0;
  int checks = 0;

  // Model state: coefficients and past samples as plain integers.
  longint cb0 = 0, cb1 = 0, cb2 = 0, ca1 = 0, ca2 = 0;
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

  always #5 clk = ~clk;

  sos_biquad_mac #(.WD(WD), .CW(CW), .FRAC(FRAC)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .b0_i(b0), .b1_i(b1), .b2_i(b2), .a1_i(a1), .a2_i(a2),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .sat_o(sat)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endfunction

  // y[n] = clip(round((b.x - a.y) / 2^FRAC))
  function automatic void model_step(input int x, output int y, output bit s);
    longint acc, q, hi, lo;
    acc = cb0 * longint'(x) + cb1 * mx1 + cb2 * mx2 - ca1 * my1 - ca2 * my2
          + (longint'(1) <<< (FRAC - 1));
    q  = acc >>> FRAC;
    hi = (longint'(1) <<< (WD - 1)) - 1;
    lo = -(longint'(1) <<< (WD - 1));
    s  = 1'b0;
    if (q > hi) begin q = hi; s = 1'b1; end
    else if (q < lo) begin q = lo; s = 1'b1; end
    mx2 = mx1; mx1 = x; my2 = my1; my1 = q;
    y = int'(q);
  endfunction

  task automatic set_coefs(input int nb0, input int nb1, input int nb2,
                           input int na1, input int na2);
    @(negedge clk);
    b0 = CW'(nb0); b1 = CW'(nb1); b2 = CW'(nb2); a1 = CW'(na1); a2 = CW'(na2);
    cb0 = longint'(b0); cb1 = longint'(b1); cb2 = longint'(b2);
    ca1 = longint'(a1); ca2 = longint'(a2);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  // Present a sample, wait for acceptance; returns the model's expectation.
  task automatic issue(input int x, output int ey, output bit es);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = WD'(x);
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
    end
    model_step(x, ey, es);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the first falling edge after the accept edge.
  task automatic collect(input string name, input int ey, input bit es,
                         input int stall, input bit take);
    int k;
    logic signed [WD-1:0] e16;
    k = 0;
    e16 = WD'(ey);
    while (!out_valid && k < 20) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k !== 5) begin errors++; $display("FAIL %s_latency: got %0d required 5", name, k); end
    checks++;
    if (out_data !== e16) begin errors++; $display("FAIL %s_data: got %0d required %0d", name, out_data, e16); end
    checks++;
    if (sat !== es) begin errors++; $display("FAIL %s_sat: got %0b required %0b", name, sat, es); end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e16 || in_ready !== 1'b0 || sat !== 1'b0) begin
        errors++;
        $display("FAIL %s_stall%0d: valid=%0b data=%0d rdy=%0b sat=%0b required 1 %0d 0 0",
                 name, i, out_valid, out_data, in_ready, sat, e16);
      end
    end
    if (take) begin
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_rdy_follow: got %0b required 1", name, in_ready); end
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || sat !== 1'b0) begin
        errors++;
        $display("FAIL %s_taken: valid=%0b sat=%0b required 0 0", name, out_valid, sat);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b required 0", sat); end
  endtask

  task automatic test_passthrough();
    int ey; bit es;
    do_clear();
    set_coefs(16384, 0, 0, 0, 0);
    issue(1000, ey, es);
    collect("pass", 1000, 1'b0, 0, 1'b1);
  endtask

  task automatic test_pure_delay();
    int ey; bit es;
    int xin [3] = '{100, 200, 300};
    int yexp[3] = '{0, 0, 100};
    do_clear();
    set_coefs(0, 0, 16384, 0, 0);
    for (int i = 0; i < 3; i++) begin
      issue(xin[i], ey, es);
      collect("delay", yexp[i], 1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_feedback();
    int ey; bit es;
    int xin [5] = '{1000, 0, 0, 0, 0};
    int yexp[5] = '{1000, 500, 250, 125, 63};
    do_clear();
    set_coefs(16384, 0, 0, -8192, 0);
    for (int i = 0; i < 5; i++) begin
      issue(xin[i], ey, es);
      collect("feedback", yexp[i], 1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_saturation();
    int ey; bit es;
    do_clear();
    set_coefs(32767, 0, 0, 0, 0);
    issue(30000, ey, es);
    collect("sat_pos", 32767, 1'b1, 0, 1'b1);
    issue(-30000, ey, es);
    collect("sat_neg", -32768, 1'b1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int ey, ey2; bit es, es2;
    do_clear();
    set_coefs(16384, 8192, 0, 4096, 0);
    issue(500, ey, es);
    collect("bp_first", ey, es, 10, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = -16'sd300;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b required 1", in_ready); end
    model_step(-300, ey2, es2);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_taken: got %0b required 0", out_valid); end
    collect("b2b", ey2, es2, 0, 1'b1);
  endtask

  // Abort a sample at cnt=2 with clear (use_rst=0) or reset (use_rst=1).
  task automatic test_abort(input bit use_rst);
    int ey; bit es; int n;
    do_clear();
    set_coefs(16384, 0, 0, 0, 0);
    issue(700, ey, es);
    collect("abort_pre", 700, 1'b0, 0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'sd400;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    model_clear();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) n++;
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL abort_no_output(rst=%0b): valid cycles %0d required 0", use_rst, n); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_idle(rst=%0b): in_ready %0b required 1", use_rst, in_ready); end
    if (use_rst) begin
      checks++;
      if (out_data !== 16'sd0) begin errors++; $display("FAIL abort_rst_data: got %0d required 0", out_data); end
    end
    issue(1000, ey, es);
    collect("abort_post", 1000, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    int ey; bit es; int x;
    for (int blk = 0; blk < 3; blk++) begin
      do_clear();
      set_coefs(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 32767)) - 16384,
                int'($urandom_range(0, 32767)) - 16384);
      for (int i = 0; i < 12; i++) begin
        x = int'($urandom_range(0, 65535)) - 32768;
        issue(x, ey, es);
        collect("rand", ey, es, int'($urandom_range(0, 3)), 1'b1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_pure_delay();
    test_feedback();
    test_saturation();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
